// File: rtl/wdma_burst_if.sv
`default_nettype none
// ============================================================================
// Module   : wdma_burst_if
// Brief    : AXI4-Stream sink plus AXI4 AW/W/B write channels for wdma_burst.
// Revision : 1.0
// ============================================================================
interface wdma_burst_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic [DATA_W-1:0]   s_axis_tdata;
   logic                s_axis_tvalid;
   logic                s_axis_tready;
   logic [ADDR_W-1:0]   m_axi_awaddr;
   logic [7:0]          m_axi_awlen;
   logic                m_axi_awvalid;
   logic                m_axi_awready;
   logic [DATA_W-1:0]   m_axi_wdata;
   logic [DATA_W/8-1:0] m_axi_wstrb;
   logic                m_axi_wlast;
   logic                m_axi_wvalid;
   logic                m_axi_wready;
   logic [1:0]          m_axi_bresp;
   logic                m_axi_bvalid;
   logic                m_axi_bready;

   modport master (
      input  s_axis_tdata, s_axis_tvalid,
      output s_axis_tready,
      output m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid,
      output m_axi_bready
   );

   modport slave (
      output s_axis_tdata, s_axis_tvalid,
      input  s_axis_tready,
      input  m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready
   );
endinterface

`default_nettype wire

// File: rtl/wdma_burst.sv
`default_nettype none
// ============================================================================
// Module   : wdma_burst
// Brief    : Stream-to-DRAM write DMA; FIFO-buffered AXI4 INCR bursts under
//            ap_start/ap_done control. WDMA_PERF_CNT_EN adds perf counters.
// Revision : 1.0
// ============================================================================
module wdma_burst #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int BURST_MAX  = 8,
   parameter int LEN_W      = 16
) (
   input  wire               ap_clk,
   input  wire               ap_rst,
   input  wire               ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   input  wire  [ADDR_W-1:0] cfg_base_addr,
   input  wire  [LEN_W-1:0]  cfg_num_beats,
   output logic              err,
`ifdef WDMA_PERF_CNT_EN
   output logic [31:0]       perf_cycles,
   output logic [31:0]       perf_stall,
`endif
   wdma_burst_if.master      bus
);

   localparam int BYTE_SH = $clog2(DATA_W / 8);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_RESP = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q;
   logic [LEN_W-1:0]    num_q, accepted_q, remaining_q;
   logic [ADDR_W-1:0]   awaddr_q;
   logic [7:0]          awlen_q, beat_q;
   logic                err_q;

   logic                awvalid, wvalid, wlast, bready, tready;
   logic                push, pop, fifo_full, fifo_empty;
   logic                start_fire, aw_fire, b_fire;
   logic [31:0]         blen_cur, rem_after, next_src, next_blen;
   logic [7:0]          next_awlen;

   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign tready     = (state_q != S_IDLE) && !fifo_full && (accepted_q < num_q);
   assign push       = bus.s_axis_tvalid && tready;
   assign pop        = wvalid && bus.m_axi_wready;
   assign start_fire = (state_q == S_IDLE) && ap_start;
   assign aw_fire    = awvalid && bus.m_axi_awready;
   assign b_fire     = bready && bus.m_axi_bvalid;

   // Burst length for the next AW: taken from cfg on start, from the remainder after a B.
   assign blen_cur   = 32'(awlen_q) + 32'd1;
   assign rem_after  = 32'(remaining_q) - blen_cur;
   assign next_src   = (state_q == S_IDLE) ? 32'(cfg_num_beats) : rem_after;
   assign next_blen  = (next_src > 32'(BURST_MAX)) ? 32'(BURST_MAX) : next_src;
   assign next_awlen = (next_blen == 32'd0) ? awlen_q : 8'(next_blen - 32'd1);

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ap_idle  = 1'b0;
      ap_done  = 1'b0;
      ap_ready = 1'b0;
      awvalid  = 1'b0;
      wvalid   = 1'b0;
      wlast    = 1'b0;
      bready   = 1'b0;
      case (state_q)
         S_IDLE: begin
            ap_idle = 1'b1;
            if (ap_start) begin
               state_d = (cfg_num_beats == '0) ? S_DONE : S_ADDR;
            end
         end
         S_ADDR: begin
            // Only announce a burst once every beat of it is already buffered.
            awvalid = (32'(count_q) >= blen_cur);
            if (awvalid && bus.m_axi_awready) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            wvalid = !fifo_empty;
            wlast  = wvalid && (beat_q == awlen_q);
            if (wlast && bus.m_axi_wready) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            bready = 1'b1;
            if (bus.m_axi_bvalid) begin
               state_d = (rem_after == 32'd0) ? S_DONE : S_ADDR;
            end
         end
         S_DONE: begin
            ap_done  = 1'b1;
            ap_ready = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge ap_clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.s_axis_tdata;
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         num_q       <= '0;
         accepted_q  <= '0;
         remaining_q <= '0;
         awaddr_q    <= '0;
         awlen_q     <= '0;
         beat_q      <= '0;
         err_q       <= 1'b0;
      end else if (start_fire) begin
         num_q       <= cfg_num_beats;
         accepted_q  <= '0;
         remaining_q <= cfg_num_beats;
         awaddr_q    <= cfg_base_addr;
         awlen_q     <= next_awlen;
         beat_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         if (push) accepted_q <= accepted_q + LEN_W'(1);
         if (aw_fire) begin
            beat_q <= '0;
         end else if (pop) begin
            beat_q <= beat_q + 8'd1;
         end
         if (b_fire) begin
            remaining_q <= remaining_q - LEN_W'(blen_cur);
            awaddr_q    <= awaddr_q + (ADDR_W'(blen_cur) << BYTE_SH);
            awlen_q     <= next_awlen;
            if (bus.m_axi_bresp != 2'b00) err_q <= 1'b1;
         end
      end
   end

`ifdef WDMA_PERF_CNT_EN
   logic [31:0] perf_cycles_q, perf_stall_q;
   logic        stall;

   assign stall = (awvalid && !bus.m_axi_awready) || (wvalid && !bus.m_axi_wready);

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         perf_cycles_q <= '0;
         perf_stall_q  <= '0;
      end else if (start_fire) begin
         perf_cycles_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if ((state_q != S_IDLE) && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 32'd1;
         if (stall && (perf_stall_q != '1))                perf_stall_q  <= perf_stall_q + 32'd1;
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stall  = perf_stall_q;
`endif

   assign err               = err_q;
   assign bus.s_axis_tready = tready;
   assign bus.m_axi_awaddr  = awaddr_q;
   assign bus.m_axi_awlen   = awlen_q;
   assign bus.m_axi_awvalid = awvalid;
   assign bus.m_axi_wdata   = mem_q[rd_ptr_q];
   assign bus.m_axi_wstrb   = '1;
   assign bus.m_axi_wlast   = wlast;
   assign bus.m_axi_wvalid  = wvalid;
   assign bus.m_axi_bready  = bready;

endmodule

`default_nettype wire

// File: tb/tb_wdma_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_wdma_burst
// Brief    : Scoreboard bench for wdma_burst: stream source, AXI write slave.
// Revision : 1.0
// ============================================================================
module tb_wdma_burst;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int LEN_W  = 16;
   localparam int BMAX   = 8;

   logic              ap_clk = 1'b0;
   logic              ap_rst = 1'b1;
   logic              ap_start = 1'b0;
   logic              ap_done, ap_idle, ap_ready, err;
   logic [ADDR_W-1:0] cfg_base_addr = '0;
   logic [LEN_W-1:0]  cfg_num_beats = '0;

   wdma_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   wdma_burst #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(16), .BURST_MAX(BMAX), .LEN_W(LEN_W)
   ) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .cfg_base_addr(cfg_base_addr), .cfg_num_beats(cfg_num_beats),
      .err(err), .bus(bus)
   );

   always #5 ap_clk = ~ap_clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Environment state
   logic [39:0] exp_aw[$];
   logic [31:0] exp_w[$];
   int          src_idx = 0, src_total = 0;
   logic [31:0] src_base = '0;
   int          wstall = 0, bad_burst = -1, burst_idx = 0;
   bit          aw_rand = 1'b0;
   int          acc_cnt = 0, wr_cnt = 0, aw_cnt = 0, exp_aw_total = 0;
   int          beat = 0, cur_len = 0;
   bit          b_pending = 1'b0, give_b = 1'b0, drop_b = 1'b0;
   bit          done_flag = 1'b0, exp_err = 1'b0, aw_wait = 1'b0;
   logic [39:0] aw_hold = '0;

   initial begin
      logic [39:0] e;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      bus.m_axi_bvalid  = 1'b0;
      bus.m_axi_bresp   = 2'b00;
      forever begin
         @(negedge ap_clk);
         if (ap_rst) begin
            exp_err = 1'b0;
            aw_wait = 1'b0;
         end else begin
            if (aw_wait)
               chk("aw_hold", {bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen}, {1'b1, aw_hold});
            aw_wait = bus.m_axi_awvalid && !bus.m_axi_awready;
            aw_hold = {bus.m_axi_awaddr, bus.m_axi_awlen};
            chk("err", err, exp_err);
            if (ap_start && ap_idle) exp_err = 1'b0;
            if (bus.s_axis_tvalid && bus.s_axis_tready) begin
               exp_w.push_back(bus.s_axis_tdata);
               src_idx++;
               acc_cnt++;
            end
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
               aw_cnt++;
               chk("aw_outstanding", b_pending, 0);
               if (exp_aw.size() == 0) begin
                  chk("aw_extra", 1, 0);
               end else begin
                  e = exp_aw.pop_front();
                  chk("awaddr", bus.m_axi_awaddr, e[39:8]);
                  chk("awlen", bus.m_axi_awlen, e[7:0]);
               end
               cur_len = int'(bus.m_axi_awlen);
               beat = 0;
            end
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
               wr_cnt++;
               if (exp_w.size() == 0) chk("w_extra", 1, 0);
               else                   chk("wdata", bus.m_axi_wdata, exp_w.pop_front());
               chk("wlast", bus.m_axi_wlast, beat == cur_len);
               chk("wstrb", bus.m_axi_wstrb, 4'hF);
               beat++;
               if (bus.m_axi_wlast) begin
                  b_pending = 1'b1;
                  give_b    = 1'b1;
               end
            end
            if (bus.m_axi_bvalid && bus.m_axi_bready) begin
               if (bus.m_axi_bresp != 2'b00) exp_err = 1'b1;
               b_pending = 1'b0;
               drop_b    = 1'b1;
               burst_idx++;
            end
            if (ap_done) begin
               done_flag = 1'b1;
               chk("ap_ready", ap_ready, 1);
            end
         end
         @(posedge ap_clk);
         #1;
         if (ap_rst) begin
            bus.s_axis_tvalid = 1'b0;
            bus.m_axi_bvalid  = 1'b0;
            give_b = 1'b0;
            drop_b = 1'b0;
         end else begin
            bus.s_axis_tvalid = (src_idx < src_total);
            bus.s_axis_tdata  = src_base + 32'(src_idx);
            bus.m_axi_awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wstall > 0) begin
               bus.m_axi_wready = 1'b0;
               wstall--;
            end else begin
               bus.m_axi_wready = 1'b1;
            end
            if (drop_b) bus.m_axi_bvalid = 1'b0;
            if (give_b) begin
               bus.m_axi_bvalid = 1'b1;
               bus.m_axi_bresp  = (burst_idx == bad_burst) ? 2'b10 : 2'b00;
            end
            give_b = 1'b0;
            drop_b = 1'b0;
         end
      end
   end

   task automatic start_xfer(input logic [31:0] base, input int num, input int extra,
                             input int stall, input bit arand, input int bad, input logic [31:0] dbase);
      logic [31:0] a;
      int rem, bl;
      src_total = 0;
      repeat (2) begin @(posedge ap_clk); #2; end
      src_idx = 0; src_base = dbase; src_total = num + extra;
      acc_cnt = 0; wr_cnt = 0; aw_cnt = 0; burst_idx = 0; bad_burst = bad;
      wstall = stall; aw_rand = arand; done_flag = 1'b0;
      a = base; rem = num; exp_aw_total = 0;
      while (rem > 0) begin
         bl = (rem > BMAX) ? BMAX : rem;
         exp_aw.push_back({a, 8'(bl - 1)});
         a = a + 32'(bl * (DATA_W / 8));
         rem -= bl;
         exp_aw_total++;
      end
      cfg_base_addr = base;
      cfg_num_beats = LEN_W'(num);
      ap_start = 1'b1;
      @(posedge ap_clk); #2;
      ap_start = 1'b0;
   endtask

   task automatic finish_xfer(input int num);
      for (int i = 0; i < 3000 && !done_flag; i++) begin
         @(posedge ap_clk); #2;
      end
      chk("done_timeout", done_flag, 1);
      chk("idle_after_done", ap_idle, 1);
      chk("done_one_cycle", ap_done, 0);
      chk("aw_count", aw_cnt, exp_aw_total);
      chk("aw_left", exp_aw.size(), 0);
      chk("w_left", exp_w.size(), 0);
      chk("accepted", acc_cnt, num);
      chk("written", wr_cnt, num);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge ap_clk);
      #2;
      chk("rst_idle", ap_idle, 1);
      chk("rst_done", ap_done, 0);
      chk("rst_tready", bus.s_axis_tready, 0);
      chk("rst_awvalid", bus.m_axi_awvalid, 0);
      chk("rst_awaddr", bus.m_axi_awaddr, 0);
      ap_rst = 1'b0;

      // 8 beats from 0x1000, two surplus beats offered that must stay unaccepted
      start_xfer(32'h1000, 8, 2, 0, 1'b0, -1, 32'd0);
      finish_xfer(8);
      chk("surplus_tready", bus.s_axis_tready, 0);
      chk("err_ok", err, 0);

      // 20 beats, three bursts, awready randomly throttled
      start_xfer(32'h1000, 20, 0, 0, 1'b1, -1, 32'hA000);
      finish_xfer(20);

      // 20 beats with wready held low for 40 cycles: FIFO must fill and throttle
      start_xfer(32'h1000, 20, 0, 40, 1'b0, -1, 32'hB000);
      repeat (35) begin @(posedge ap_clk); #2; end
      chk("full_tready", bus.s_axis_tready, 0);
      chk("fifo_occ", acc_cnt - wr_cnt, 16);
      finish_xfer(20);

      // zero beats: immediate completion, no AXI traffic
      done_flag = 1'b0; aw_cnt = 0; wr_cnt = 0;
      cfg_num_beats = '0;
      ap_start = 1'b1;
      @(posedge ap_clk); #2;
      ap_start = 1'b0;
      chk("zero_done", ap_done, 1);
      chk("zero_ready", ap_ready, 1);
      chk("zero_idle_low", ap_idle, 0);
      @(posedge ap_clk); #2;
      chk("zero_done_clr", ap_done, 0);
      chk("zero_idle", ap_idle, 1);
      repeat (3) begin @(posedge ap_clk); #2; end
      chk("zero_aw", aw_cnt, 0);
      chk("zero_w", wr_cnt, 0);

      // second burst answered SLVERR: err sticky, transfer completes
      start_xfer(32'h4000, 20, 0, 0, 1'b0, 1, 32'hC000);
      finish_xfer(20);
      chk("err_sticky", err, 1);

      // next start clears err
      start_xfer(32'h5000, 8, 0, 0, 1'b0, -1, 32'hD000);
      chk("err_cleared", err, 0);
      finish_xfer(8);

      // reset during DATA of first burst
      start_xfer(32'h3000, 8, 0, 0, 1'b0, -1, 32'hE000);
      for (int i = 0; i < 200 && wr_cnt < 2; i++) begin @(posedge ap_clk); #2; end
      chk("reset_reach_data", wr_cnt >= 2, 1);
      ap_rst = 1'b1;
      #1;
      chk("mid_rst_idle", ap_idle, 1);
      chk("mid_rst_done", ap_done, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_tready", bus.s_axis_tready, 0);
      chk("mid_rst_awvalid", bus.m_axi_awvalid, 0);
      chk("mid_rst_wvalid", bus.m_axi_wvalid, 0);
      chk("mid_rst_wlast", bus.m_axi_wlast, 0);
      chk("mid_rst_bready", bus.m_axi_bready, 0);
      chk("mid_rst_awaddr", bus.m_axi_awaddr, 0);
      chk("mid_rst_awlen", bus.m_axi_awlen, 0);
      src_total = 0;
      exp_aw.delete();
      exp_w.delete();
      b_pending = 1'b0;
      done_flag = 1'b0;
      repeat (3) begin @(posedge ap_clk); #2; end
      ap_rst = 1'b0;
      start_xfer(32'h2000, 4, 0, 0, 1'b0, -1, 32'hF000);
      finish_xfer(4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

`default_nettype wire
